// File: rtl/lsu_mem_req_ctrl.sv
// Load/store request controller: buffers LSU memory ops, issues them one at a time to the
// data scratchpad and broadcasts tagged results (or misalign/timeout exceptions) on the CDB.
module lsu_mem_req_ctrl #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned TAG_W      = 6,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_store,
    input  logic             in_is_atomic,
    input  logic             in_unsigned,
    input  logic [1:0]       in_size,
    input  logic [XLEN-1:0]  in_addr,
    input  logic [XLEN-1:0]  in_wdata,
    input  logic [XLEN-1:0]  in_cmp_val,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mem_req,
    output logic             mem_we,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    output logic [1:0]       mem_size,
    output logic             mem_atomic,
    output logic [XLEN-1:0]  mem_cmp_val,
    input  logic             mem_ready,
    input  logic [XLEN-1:0]  mem_rdata,
    input  logic             mem_error,
    output logic             cdb_valid,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [XLEN-1:0]  cdb_data,
    output logic             cdb_exc,
    output logic [1:0]       cdb_exc_code,
    output logic             busy
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic             is_store;
        logic             is_atomic;
        logic             is_unsigned;
        logic [1:0]       size;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  wdata;
        logic [XLEN-1:0]  cmp_val;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             kill_q, kill_d;
    op_t              fifo_q [FIFO_DEPTH];
    op_t              fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             cdb_valid_q, cdb_valid_d, cdb_exc_q, cdb_exc_d;
    logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [XLEN-1:0]  cdb_data_q, cdb_data_d;
    logic [1:0]       cdb_code_q, cdb_code_d;

    op_t              head;
    logic             is_req, push, pop, done, deliver, res_exc;
    logic [XLEN-1:0]  res_data;
    logic [1:0]       res_code;

    function automatic logic [XLEN-1:0] load_value(input op_t op, input logic [XLEN-1:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{op.addr[1:0], 3'b000} +: 8];
        h = rd[{op.addr[1], 4'b0000} +: 16];
        if (op.is_atomic) return rd;
        if (op.is_store)  return '0;
        unique case (op.size)
            2'b00:   return op.is_unsigned ? {{(XLEN-8){1'b0}}, b} : {{(XLEN-8){b[7]}}, b};
            2'b01:   return op.is_unsigned ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
            default: return rd;
        endcase
    endfunction

    assign head     = fifo_q[rd_ptr_q];
    assign is_req   = (state_q == S_REQ);
    assign in_ready = (count_q != CNT_W'(FIFO_DEPTH));
    assign busy     = (count_q != '0) || (state_q != S_IDLE);

    assign mem_req     = is_req;
    assign mem_we      = is_req && head.is_store && !head.is_atomic;
    assign mem_atomic  = is_req && head.is_atomic;
    assign mem_size    = is_req ? (head.is_atomic ? 2'b10 : head.size) : 2'b00;
    assign mem_addr    = is_req ? head.addr    : '0;
    assign mem_wdata   = is_req ? head.wdata   : '0;
    assign mem_cmp_val = is_req ? head.cmp_val : '0;

    assign cdb_valid    = cdb_valid_q;
    assign cdb_tag      = cdb_tag_q;
    assign cdb_data     = cdb_data_q;
    assign cdb_exc      = cdb_exc_q;
    assign cdb_exc_code = cdb_code_q;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        done     = 1'b0;
        res_data = '0;
        res_exc  = 1'b0;
        res_code = 2'b00;
        unique case (state_q)
            S_IDLE: if (count_q != '0 && !flush) state_d = S_REQ;
            S_REQ: begin
                if (mem_error) begin
                    done     = 1'b1;
                    res_exc  = 1'b1;
                    res_code = 2'b01;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                    tmr_d   = '0;
                end
            end
            S_WAIT: begin
                if (mem_ready) begin
                    done     = 1'b1;
                    res_data = load_value(head, mem_rdata);
                    state_d  = S_IDLE;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    done     = 1'b1;
                    res_exc  = 1'b1;
                    res_code = 2'b10;
                    state_d  = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A flushed op keeps running at the scratchpad but its result is dropped on completion.
        kill_d  = (state_d != S_IDLE) && (kill_q || flush);
        deliver = done && !kill_q && !flush;

        cdb_valid_d = deliver;
        cdb_tag_d   = deliver ? head.tag : '0;
        cdb_data_d  = deliver ? res_data : '0;
        cdb_exc_d   = deliver && res_exc;
        cdb_code_d  = deliver ? res_code : 2'b00;
    end

    always_comb begin
        push = in_valid && in_ready && !flush;
        pop  = deliver;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_d[i] = fifo_q[i];
        if (push) begin
            fifo_d[wr_ptr_q] = '{is_store: in_is_store, is_atomic: in_is_atomic,
                                 is_unsigned: in_unsigned, size: in_size, addr: in_addr,
                                 wdata: in_wdata, cmp_val: in_cmp_val, tag: in_tag};
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            kill_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_exc_q   <= 1'b0;
            cdb_code_q  <= 2'b00;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            kill_q      <= kill_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_exc_q   <= cdb_exc_d;
            cdb_code_q  <= cdb_code_d;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= fifo_d[i];
        end
    end
endmodule
